// File: rtl/cpu_pkg.sv
// Shared core types: word/register sizes, load encodings,
// and the writeback state machine encoding.
package cpu_pkg;

    localparam int regBits  = 5;
    localparam int wordBits = 32;

    typedef logic [wordBits-1:0] word_t;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_t;

endpackage

// File: rtl/load_extend.sv
// Load data formatter: picks the byte/half/word out of the
// aligned memory word and extends it; flags bad type/alignment.
module load_extend
    import cpu_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic [WORD_W-1:0] raw,
    output logic [WORD_W-1:0] data,
    output logic              fault
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane select followed by sign/zero extension per load type
    always_comb begin
        byte_v = raw[{addr_lo, 3'b000} +: 8];
        half_v = raw[{addr_lo[1], 4'b0000} +: 16];
        data   = '0;
        fault  = 1'b0;
        case (load_funct3_t'(funct3))
            LB: begin
                data = {{(WORD_W-8){byte_v[7]}}, byte_v};
            end
            LH: begin
                data  = {{(WORD_W-16){half_v[15]}}, half_v};
                fault = addr_lo[0];
            end
            LW: begin
                data  = raw;
                fault = (addr_lo != 2'b00);
            end
            LBU: begin
                data = {{(WORD_W-8){1'b0}}, byte_v};
            end
            LHU: begin
                data  = {{(WORD_W-16){1'b0}}, half_v};
                fault = addr_lo[0];
            end
            default: begin
                fault = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: retires ALU results and one outstanding load
// into the register file, with load timeout and stall signalling.
module writeback_unit
    import cpu_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int REG_AW  = regBits,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [WORD_W-1:0] alu_result,
    input  logic              ld_valid,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic [2:0]        ld_funct3,
    input  logic [1:0]        ld_addr_lo,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              reg_write,
    output logic [REG_AW-1:0] write_index,
    output logic [WORD_W-1:0] write_data,
    output logic              busy,
    output logic              load_fault,
    output logic              protocol_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    wb_state_t         state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lo_q, lo_d;

    logic              we_d;
    logic [REG_AW-1:0] idx_d;
    logic [WORD_W-1:0] data_d;
    logic              fault_d;
    logic              perr_d;

    logic [WORD_W-1:0] ext_data;
    logic              ext_fault;

    load_extend #(
        .WORD_W(WORD_W)
    ) u_ext (
        .funct3 (f3_q),
        .addr_lo(lo_q),
        .raw    (mem_rdata),
        .data   (ext_data),
        .fault  (ext_fault)
    );

    // State, latched load info and all registered outputs
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state        <= IDLE;
            cnt          <= '0;
            rd_q         <= '0;
            f3_q         <= '0;
            lo_q         <= '0;
            reg_write    <= 1'b0;
            write_index  <= '0;
            write_data   <= '0;
            busy         <= 1'b0;
            load_fault   <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            rd_q         <= rd_d;
            f3_q         <= f3_d;
            lo_q         <= lo_d;
            reg_write    <= we_d;
            write_index  <= idx_d;
            write_data   <= data_d;
            busy         <= (state_d == WAIT_MEM);
            load_fault   <= fault_d;
            protocol_err <= perr_d;
        end
    end

    // Next state and next output values
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        rd_d    = rd_q;
        f3_d    = f3_q;
        lo_d    = lo_q;
        we_d    = 1'b0;
        idx_d   = write_index;
        data_d  = write_data;
        fault_d = 1'b0;
        perr_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (alu_valid) begin
                    we_d   = (alu_rd != '0);
                    idx_d  = alu_rd;
                    data_d = alu_result;
                end
                if (ld_valid) begin
                    rd_d    = ld_rd;
                    f3_d    = ld_funct3;
                    lo_d    = ld_addr_lo;
                    cnt_d   = '0;
                    state_d = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                perr_d = alu_valid | ld_valid;
                if (mem_ack) begin
                    state_d = IDLE;
                    if (ext_fault) begin
                        fault_d = 1'b1;
                    end else begin
                        we_d   = (rd_q != '0);
                        idx_d  = rd_q;
                        data_d = ext_data;
                    end
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
Writeback stage directly upstream of the register file write port. Accepts single-cycle ALU results and multi-cycle load completions, formats load data (byte/half/word, sign/zero extend), and drives reg_write/write_index/write_data into the register file. Tracks one outstanding load with a timeout and raises busy so the pipeline stalls while a load is in flight.

Parameters:
WORD_W, 32, data width (matches word_t)
REG_AW, 5, register index width (matches regBits)
TIMEOUT, 255, max cycles in WAIT_MEM before abandoning a load (>=2)

Ports:
clk  input  1  clock, all state on rising edge
nRst  input  1  asynchronous active-low reset
alu_valid  input  1  ALU result present this cycle
alu_rd  input  REG_AW  ALU destination register
alu_result  input  WORD_W  ALU result
ld_valid  input  1  load issued this cycle
ld_rd  input  REG_AW  load destination register
ld_funct3  input  3  RV32I load type
ld_addr_lo  input  2  load address bits [1:0]
mem_ack  input  1  memory read data valid
mem_rdata  input  WORD_W  raw aligned memory word
reg_write  output  1  register file write enable
write_index  output  REG_AW  register file write index
write_data  output  WORD_W  register file write data
busy  output  1  load outstanding; upstream must hold
load_fault  output  1  one-cycle pulse: bad funct3, misalignment, or timeout
protocol_err  output  1  one-cycle pulse: alu_valid/ld_valid presented while busy

Behaviour:
- Reset (nRst low, async): state IDLE, timeout counter 0, all outputs 0. Reset mid-load abandons it; no write after release.
- States: IDLE, WAIT_MEM. All outputs registered.
- IDLE, alu_valid: next cycle reg_write=1, write_index=alu_rd, write_data=alu_result (latency 1).
- IDLE, ld_valid: latch ld_rd, ld_funct3, ld_addr_lo; clear counter; next state WAIT_MEM; busy=1 from next cycle.
- IDLE, both valid same cycle: ALU write proceeds (older), load also accepted.
- WAIT_MEM: counter increments each cycle without mem_ack. mem_ack arriving: format data; next cycle reg_write=1 with formatted value; state IDLE, busy=0 same edge. Counter reaching TIMEOUT-1 with no ack: load_fault pulse, IDLE, no write. Ack on the timeout cycle wins (write, no fault).
- mem_ack in IDLE: ignored.
- Formatting by funct3: 000 LB sign-extend byte at addr_lo; 001 LH sign-extend half at addr_lo[1]; 010 LW full word; 100 LBU, 101 LHU zero-extend. Other funct3, LH/LHU with addr_lo[0]=1, or LW with addr_lo!=0: on ack, load_fault pulse, no write.
- rd=0 (either source): reg_write stays 0; load still tracked and busy still asserted until ack/timeout.
- alu_valid or ld_valid while in WAIT_MEM: input dropped, protocol_err pulse next cycle, state unaffected.
- reg_write is a single-cycle pulse per accepted result; at most one write per cycle.

Decomposition:
- cpu_pkg: reuse word_t, regBits; add load_funct3_t enum (LB, LH, LW, LBU, LHU) and wb_state_t (IDLE, WAIT_MEM).
- Sub-module load_extend (combinational): funct3, addr_lo, raw word -> formatted word, fault flag.

Test Plan:
- Reset then alu_valid, rd=5, result=0xDEADBEEF -> next cycle reg_write=1, write_index=5, write_data=0xDEADBEEF; following cycle reg_write=0.
- ld LB rd=3 addr_lo=2, ack after 4 cycles with rdata=0x12F45678 -> busy high 4 cycles, then write_data=0xFFFFFFF4 to x3; LBU same -> 0x000000F4; LH addr_lo=2 -> 0x000012F4.
- ld LW addr_lo=1 with ack rdata=0x11223344 -> load_fault pulse, no reg_write; ld funct3=011 -> same.
- ld with TIMEOUT=8, no ack -> load_fault on timeout, busy drops, no write; repeat with ack on final cycle -> write, no fault.
- Same-cycle alu_valid rd=7 and ld_valid rd=7; ack rdata=0x00000042 (LW) -> first write 7<-ALU value, later 7<-0x42; alu_valid during WAIT_MEM -> protocol_err, no write.
- ALU and load to rd=0 -> reg_write never asserted; assert nRst low mid-WAIT_MEM then ack after release -> no write, busy=0.
